iter_sequencer: RTL and testbench

Parametrised controller for the Mandelbrot escape-time datapath. For each pixel of a frame it sequences pixel-map load/init and NUM_STAGES calculation stages per iteration. It counts iterations, stops on escape or MAX_ITER, and hands the result downstream on a valid/ready handshake. It sits between the pixel coordinate mapper / iteration datapath and the output queue, and replaces the fixed two-stage controller with a generalised stage count, iteration limit, frame length and explicit result output.

---
 rtl/iter_sequencer_if.sv | 34 +++
 rtl/iter_sequencer.sv | 122 ++++++++++++
 tb/tb_iter_sequencer.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/iter_sequencer_if.sv
// Handshake and control bundle between the escape-time sequencer and its
// surroundings: the coordinate mapper, the iteration datapath and the output queue.
interface iter_sequencer_if #(
  parameter int NUM_STAGES = 2,
  parameter int ITER_W     = 8,
  parameter int PIX_W      = 19
);
  logic                  start;
  logic                  escaped;
  logic                  out_ready;
  logic                  init;
  logic                  en_pixel_map;
  logic [NUM_STAGES-1:0] stage_en;
  logic                  out_valid;
  logic [ITER_W-1:0]     out_iter;
  logic                  out_escaped;
  logic [PIX_W-1:0]      out_pixel;
  logic                  busy;
  logic                  frame_done;

  // The sequencer side drives the enables and the result.
  modport master (
    input  start, escaped, out_ready,
    output init, en_pixel_map, stage_en, out_valid, out_iter,
           out_escaped, out_pixel, busy, frame_done
  );

  // The environment side drives the frame start, escape flag and result ready.
  modport slave (
    output start, escaped, out_ready,
    input  init, en_pixel_map, stage_en, out_valid, out_iter,
           out_escaped, out_pixel, busy, frame_done
  );
endinterface

// File: rtl/iter_sequencer.sv
// Per-pixel controller for the Mandelbrot escape-time datapath: init, NUM_STAGES
// calc stages per iteration, escape/limit check, then a valid/ready result.
module iter_sequencer #(
  parameter int NUM_STAGES = 2,
  parameter int ITER_W     = 8,
  parameter int MAX_ITER   = 255,
  parameter int PIX_W      = 19,
  parameter int NUM_PIXELS = 307200
) (
  input  logic          clk,
  input  logic          rst,
  iter_sequencer_if.master bus
);
  localparam int IDX_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_STAGES - 1);
  localparam logic [ITER_W-1:0] ITER_LIM = ITER_W'(MAX_ITER);
  localparam logic [PIX_W-1:0]  LAST_PIX = PIX_W'(NUM_PIXELS - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    INIT  = 3'd1,
    STAGE = 3'd2,
    CHECK = 3'd3,
    EMIT  = 3'd4
  } state_t;

  state_t            state_reg;
  logic [IDX_W-1:0]  idx_reg;
  logic [ITER_W-1:0] iter_reg;
  logic [ITER_W-1:0] out_iter_reg;
  logic [PIX_W-1:0]  pixel_reg;
  logic [PIX_W-1:0]  out_pixel_reg;
  logic              out_escaped_reg;
  logic              frame_done_reg;
  logic [ITER_W-1:0] iter_next;

  // Cannot wrap: MAX_ITER fits in ITER_W and the limit test stops at MAX_ITER.
  assign iter_next = iter_reg + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg       <= IDLE;
      idx_reg         <= '0;
      iter_reg        <= '0;
      pixel_reg       <= '0;
      out_iter_reg    <= '0;
      out_escaped_reg <= 1'b0;
      out_pixel_reg   <= '0;
      frame_done_reg  <= 1'b0;
    end else begin
      frame_done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            pixel_reg <= '0;
            state_reg <= INIT;
          end
        end
        INIT: begin
          iter_reg  <= '0;
          idx_reg   <= '0;
          state_reg <= STAGE;
        end
        STAGE: begin
          if (idx_reg == LAST_IDX) begin
            state_reg <= CHECK;
          end else begin
            idx_reg <= idx_reg + 1'b1;
          end
        end
        CHECK: begin
          // Escape takes priority so a final-iteration escape still reports escaped.
          if (bus.escaped) begin
            out_iter_reg    <= iter_next;
            out_escaped_reg <= 1'b1;
            out_pixel_reg   <= pixel_reg;
            state_reg       <= EMIT;
          end else if (iter_next == ITER_LIM) begin
            out_iter_reg    <= ITER_LIM;
            out_escaped_reg <= 1'b0;
            out_pixel_reg   <= pixel_reg;
            state_reg       <= EMIT;
          end else begin
            iter_reg  <= iter_next;
            idx_reg   <= '0;
            state_reg <= STAGE;
          end
        end
        EMIT: begin
          if (bus.out_ready) begin
            if (pixel_reg == LAST_PIX) begin
              pixel_reg      <= '0;
              frame_done_reg <= 1'b1;
              state_reg      <= IDLE;
            end else begin
              pixel_reg <= pixel_reg + 1'b1;
              state_reg <= INIT;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.init         = (state_reg == INIT);
  assign bus.en_pixel_map = (state_reg == INIT);
  assign bus.out_valid    = (state_reg == EMIT);
  assign bus.busy         = (state_reg != IDLE);
  assign bus.out_iter     = out_iter_reg;
  assign bus.out_escaped  = out_escaped_reg;
  assign bus.out_pixel    = out_pixel_reg;
  assign bus.frame_done   = frame_done_reg;

  // One-hot stage enable, one decoder bit per calc stage.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_STAGES; gi++) begin : g_stage_en
      assign bus.stage_en[gi] = (state_reg == STAGE) && (idx_reg == IDX_W'(gi));
    end
  endgenerate
endmodule

// File: tb/tb_iter_sequencer.sv
// Directed bench for iter_sequencer with NUM_STAGES=2, MAX_ITER=4, NUM_PIXELS=3.
module tb_iter_sequencer;
  localparam int NUM_STAGES = 2;
  localparam int ITER_W     = 8;
  localparam int MAX_ITER   = 4;
  localparam int PIX_W      = 4;
  localparam int NUM_PIXELS = 3;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  iter_sequencer_if #(.NUM_STAGES(NUM_STAGES), .ITER_W(ITER_W), .PIX_W(PIX_W)) bus ();

  iter_sequencer #(
    .NUM_STAGES(NUM_STAGES),
    .ITER_W    (ITER_W),
    .MAX_ITER  (MAX_ITER),
    .PIX_W     (PIX_W),
    .NUM_PIXELS(NUM_PIXELS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_init"},        32'(bus.init),         0);
    chk({tag, "_en_map"},      32'(bus.en_pixel_map), 0);
    chk({tag, "_stage_en"},    32'(bus.stage_en),     0);
    chk({tag, "_out_valid"},   32'(bus.out_valid),    0);
    chk({tag, "_out_iter"},    32'(bus.out_iter),     0);
    chk({tag, "_out_escaped"}, 32'(bus.out_escaped),  0);
    chk({tag, "_out_pixel"},   32'(bus.out_pixel),    0);
    chk({tag, "_busy"},        32'(bus.busy),         0);
    chk({tag, "_frame_done"},  32'(bus.frame_done),   0);
  endtask

  // Entered with the DUT showing INIT; leaves it showing EMIT.
  // escaped is pulsed during a STAGE cycle too, where it must be ignored.
  task automatic do_pixel(input int n_iter, input bit esc, input int pix);
    chk("init",       32'(bus.init),         1);
    chk("en_map",     32'(bus.en_pixel_map), 1);
    chk("init_busy",  32'(bus.busy),         1);
    chk("init_stage", 32'(bus.stage_en),     0);
    for (int k = 1; k <= n_iter; k++) begin
      tick();
      chk("stage0", 32'(bus.stage_en), 32'h1);
      bus.escaped = 1'b1;
      tick();
      chk("stage1", 32'(bus.stage_en), 32'h2);
      bus.escaped = 1'b0;
      tick();
      chk("check_stage", 32'(bus.stage_en),  0);
      chk("check_valid", 32'(bus.out_valid), 0);
      chk("check_init",  32'(bus.init),      0);
      bus.escaped = (k == n_iter) && esc;
    end
    tick();
    bus.escaped = 1'b0;
    chk("emit_valid",   32'(bus.out_valid),   1);
    chk("emit_iter",    32'(bus.out_iter),    32'(n_iter));
    chk("emit_escaped", 32'(bus.out_escaped), 32'(esc));
    chk("emit_pixel",   32'(bus.out_pixel),   32'(pix));
    chk("emit_stage",   32'(bus.stage_en),    0);
  endtask

  initial begin
    rst           = 1'b0;
    bus.start     = 1'b1;
    bus.escaped   = 1'b0;
    bus.out_ready = 1'b1;

    // Reset held with start asserted
    tick();
    tick();
    chk_all_zero("rst");
    rst       = 1'b1;
    bus.start = 1'b0;
    tick();
    tick();
    chk("idle_busy", 32'(bus.busy), 0);
    chk("idle_init", 32'(bus.init), 0);

    // Pixel 0: escape in first CHECK, 1-cycle EMIT
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    do_pixel(1, 1'b1, 0);
    tick();

    // Pixel 1: runs to MAX_ITER, then 5 cycles of backpressure
    bus.out_ready = 1'b0;
    bus.start     = 1'b1;  // ignored while busy
    do_pixel(4, 1'b0, 1);
    bus.start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_valid",   32'(bus.out_valid),    1);
      chk("bp_iter",    32'(bus.out_iter),     4);
      chk("bp_escaped", 32'(bus.out_escaped),  0);
      chk("bp_pixel",   32'(bus.out_pixel),    1);
      chk("bp_init",    32'(bus.init),         0);
      chk("bp_en_map",  32'(bus.en_pixel_map), 0);
      chk("bp_stage",   32'(bus.stage_en),     0);
    end
    bus.out_ready = 1'b1;
    tick();

    // Pixel 2 (last): escape on the MAX_ITER-th iteration
    do_pixel(4, 1'b1, 2);
    tick();
    chk("fd_pulse", 32'(bus.frame_done), 1);
    chk("fd_busy",  32'(bus.busy),       0);
    chk("fd_valid", 32'(bus.out_valid),  0);
    tick();
    chk("fd_clear", 32'(bus.frame_done), 0);
    chk("fd_idle",  32'(bus.busy),       0);

    // New frame restarts at pixel 0
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    do_pixel(1, 1'b1, 0);
    tick();
    chk("f2_init_p1", 32'(bus.init), 1);

    // Reset during STAGE of pixel 1 abandons it
    tick();
    chk("f2_stage0", 32'(bus.stage_en), 32'h1);
    rst = 1'b0;
    tick();
    chk_all_zero("midrst");
    rst = 1'b1;
    tick();
    chk("midrst_idle", 32'(bus.busy), 0);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    do_pixel(2, 1'b1, 0);
    tick();
    chk("post_init_p1", 32'(bus.init), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
